timer_tick_gen: RTL and testbench

- Control front end for the timer up/down counter: produces the counter's up/down strobes and reads back its value and overflow flag.
- Prescales clk into ticks and runs one of four counting modes (one-shot up, one-shot down, triangle, free-run).
- Reports completion (done) and period events (period) to the timer register/IRQ logic.

---
 rtl/timer_tick_gen.sv | 80 ++++++++
 tb/tb_timer_tick_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/timer_tick_gen.sv
// timer_tick_gen: prescaled up/down strobe front end for the timer counter.
// Optional pause input enabled by defining TIMER_TICK_PAUSE_EN.
module timer_tick_gen #(
  parameter int COUNTER_SIZE = 8,
  parameter int PRESCALE_SIZE = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [1:0]               mode,
  input  logic [PRESCALE_SIZE-1:0] prescale,
  input  logic [COUNTER_SIZE-1:0]  top,
  input  logic [COUNTER_SIZE-1:0]  value,
  input  logic                     overflow,
`ifdef TIMER_TICK_PAUSE_EN
  input  logic                     pause,
`endif
  output logic                     up,
  output logic                     down,
  output logic                     busy,
  output logic                     done,
  output logic                     period
);
  typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN} state_t;
  state_t state, state_n;
  logic [PRESCALE_SIZE-1:0] cnt, p;
  logic [COUNTER_SIZE-1:0] t;
  logic [1:0] m;
  logic ov_d, run, hold, tick, at_top, at_zero, done_n, period_n;
`ifdef TIMER_TICK_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif
  assign run = state != IDLE;
  assign tick = run && !hold && cnt == '0;
  assign at_top = value == t;
  assign at_zero = value == '0;
  // an extreme reached on a tick either ends a one-shot or turns a triangle around
  always_comb begin
    up = tick && !stop && state == RUN_UP && (m == 2'b11 || !at_top);
    down = tick && !stop && state == RUN_DOWN && !at_zero;
    state_n = state;
    done_n = 1'b0;
    period_n = run && !stop && m == 2'b11 && overflow && !ov_d;
    if (state == IDLE) state_n = start && !stop ? (mode == 2'b01 ? RUN_DOWN : RUN_UP) : IDLE;
    else if (stop) state_n = IDLE;
    else if (tick && m != 2'b11 && (state == RUN_UP ? at_top : at_zero)) begin
      state_n = m[1] ? (state == RUN_UP ? RUN_DOWN : RUN_UP) : IDLE;
      done_n = !m[1];
      period_n = m[1];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      p <= '0;
      t <= '0;
      m <= '0;
      ov_d <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      period <= 1'b0;
    end else begin
      state <= state_n;
      ov_d <= overflow;
      busy <= state_n != IDLE;
      done <= done_n;
      period <= period_n;
      if (state == IDLE && start && !stop) begin
        m <= mode;
        t <= top;
        p <= prescale;
        cnt <= prescale;
      end else if (run && !hold) cnt <= tick ? p : cnt - PRESCALE_SIZE'(1);
    end
  end
endmodule

// File: tb/tb_timer_tick_gen.sv
// tb_timer_tick_gen: random and directed runs against a tick-timeline reference model.
module tb_timer_tick_gen;
  localparam int CW = 4;
  localparam int PW = 3;
  localparam int MSK = (1 << CW) - 1;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [1:0] mode = '0;
  logic [PW-1:0] prescale = '0;
  logic [CW-1:0] top = '0, value = '0, ldv = '0;
  logic overflow = 1'b0, ld = 1'b1;
`ifdef TIMER_TICK_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic up, down, busy, done, period;
  int errs = 0, checks = 0;
  logic e_up[0:299], e_dn[0:299], e_done[0:299], e_per[0:299], e_busy[0:299];

  always #5 clk = ~clk;

  timer_tick_gen #(.COUNTER_SIZE(CW), .PRESCALE_SIZE(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .prescale(prescale), .top(top), .value(value), .overflow(overflow),
`ifdef TIMER_TICK_PAUSE_EN
    .pause(pause),
`endif
    .up(up), .down(down), .busy(busy), .done(done), .period(period)
  );

  // the counter the strobes drive; overflow lags value by one cycle
  always @(posedge clk) begin
    value <= ld ? ldv : value + CW'(up) - CW'(down);
    overflow <= (value == CW'(MSK));
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // expected events come from the tick schedule: tick k lands in cycle (k+1)*(p+1)
  task automatic run_case(input int m, input int p, input int tp, input int v0, input int sct);
    int sc, te, eb, tc, n, j, r, act, len;
    for (int i = 0; i < 300; i++) begin
      e_up[i] = 0; e_dn[i] = 0; e_done[i] = 0; e_per[i] = 0; e_busy[i] = 0;
    end
    sc = sct >= 0 ? (sct + 1) * (p + 1) : 1000;
    te = 1000;
    for (int k = 0; k < 280; k++) begin
      tc = (k + 1) * (p + 1);
      if (tc >= sc || tc > 280) break;
      if (m == 0) begin n = (tp - v0) & MSK; act = k < n ? 1 : 4; end
      else if (m == 1) act = k < v0 ? 2 : 4;
      else if (m == 3) begin
        act = 1;
        if (((v0 + k + 1) & MSK) == MSK && tc + 2 < sc) e_per[tc + 3] = 1;
      end else begin
        n = (tp - v0) & MSK;
        if (k < n) act = 1;
        else if (k == n) act = 3;
        else begin
          j = k - n - 1;
          r = j % (tp + 1);
          act = r < tp ? (((j / (tp + 1)) % 2 == 0) ? 2 : 1) : 3;
        end
      end
      if (act == 1) e_up[tc] = 1;
      if (act == 2) e_dn[tc] = 1;
      if (act == 3) e_per[tc + 1] = 1;
      if (act == 4) begin te = tc; e_done[tc + 1] = 1; break; end
    end
    eb = te < sc ? te : sc;
    for (int c = 1; c <= eb; c++) e_busy[c] = 1;
    len = eb + 3;
    ld = 1'b1;
    ldv = CW'(v0);
    repeat (3) @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    mode = 2'(m); top = CW'(tp); prescale = PW'(p); start = 1'b1; stop = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_up", up, 0);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      start = e_busy[c] ? 1'($urandom) : 1'b0;
      stop = (c == sc);
      mode = 2'($urandom); top = CW'($urandom); prescale = PW'($urandom);
      #1;
      chk($sformatf("m%0d up@%0d", m, c), up, e_up[c]);
      chk($sformatf("m%0d down@%0d", m, c), down, e_dn[c]);
      chk($sformatf("m%0d done@%0d", m, c), done, e_done[c]);
      chk($sformatf("m%0d period@%0d", m, c), period, e_per[c]);
      chk($sformatf("m%0d busy@%0d", m, c), busy, e_busy[c]);
    end
    start = 1'b0;
    stop = 1'b0;
    if (m < 2 && te < sc) chk($sformatf("m%0d final_value", m), value, 8'(m == 0 ? tp : 0));
  endtask

  initial begin
    int m;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_up", up, 0);
    chk("rst_down", down, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_period", period, 0);
    rst = 1'b0;
    run_case(0, 2, 3, 0, -1);
    run_case(1, 0, 0, 5, -1);
    run_case(2, 0, 2, 0, 11);
    run_case(3, 0, 0, 0, 39);
    run_case(0, 0, 10, 0, 1);
    @(negedge clk);
    start = 1'b1; stop = 1'b1; mode = 2'b00; top = 4'd5; prescale = '0;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    #1;
    chk("startstop_busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("startstop_up", up, 0);
    end
    repeat (25) begin
      m = int'($urandom_range(0, 3));
      run_case(m, int'($urandom_range(0, 3)), int'($urandom_range(0, MSK)), int'($urandom_range(0, MSK)),
               (m >= 2 || $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1);
    end
    ld = 1'b1; ldv = '0;
    repeat (2) @(negedge clk);
    ld = 1'b0;
    start = 1'b1; mode = 2'b00; top = 4'd10; prescale = '0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("prerst_up", up, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_up", up, 0);
    chk("arst_down", down, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_period", period, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
